// File: rtl/gfx_sdram_arbiter_if.sv
// -----------------------------------------------------------------------------
// gfx_sdram_arbiter_if
//
// Bundles every non-clock signal around the graphics SDRAM arbiter: the ROM
// download port, the two graphics read requesters (bg, obj), the SDRAM
// controller port and the sticky watchdog flag.
//
// Modports:
//   master : the arbiter itself. It drives the SDRAM strobes, address and
//            write data, the requester acks/data, dl_wait and err.
//   slave  : the surroundings (loader, fetch engines, SDRAM controller).
//
// Handshake rules, for every agent on this bundle:
//   - dl_wr is a one-cycle strobe. dl_wait high means the single write
//     holding register is full; a dl_wr seen while it is full is dropped.
//   - bg_req / obj_req are levels. Address is sampled at grant, and req must
//     stay high until the matching one-cycle *_ack. *_data is valid with
//     *_ack and is held afterwards.
//   - sd_rd / sd_we are one-cycle strobes, never high together. The SDRAM
//     answers each with exactly one sd_ready pulse, read data on sd_dout in
//     that same cycle. Only one SDRAM op is in flight at a time.
// -----------------------------------------------------------------------------
interface gfx_sdram_arbiter_if;
  logic        dl_active;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;

  logic        bg_req;
  logic [18:0] bg_addr;
  logic        bg_ack;
  logic [7:0]  bg_data;

  logic        obj_req;
  logic [18:0] obj_addr;
  logic        obj_ack;
  logic [7:0]  obj_data;

  logic [24:0] sd_addr;
  logic [7:0]  sd_din;
  logic        sd_rd;
  logic        sd_we;
  logic [7:0]  sd_dout;
  logic        sd_ready;

  logic        err;

  modport master (
    input  dl_active, dl_wr, dl_addr, dl_data,
    output dl_wait,
    input  bg_req, bg_addr,
    output bg_ack, bg_data,
    input  obj_req, obj_addr,
    output obj_ack, obj_data,
    output sd_addr, sd_din, sd_rd, sd_we,
    input  sd_dout, sd_ready,
    output err
  );

  modport slave (
    output dl_active, dl_wr, dl_addr, dl_data,
    input  dl_wait,
    output bg_req, bg_addr,
    input  bg_ack, bg_data,
    output obj_req, obj_addr,
    input  obj_ack, obj_data,
    input  sd_addr, sd_din, sd_rd, sd_we,
    output sd_dout, sd_ready,
    input  err
  );
endinterface

// File: rtl/gfx_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// gfx_sdram_arbiter
//
// Shares one SDRAM port between the ROM loader (writes) and two graphics
// fetch engines (background tiles, sprites; reads). Loader writes go through
// a one-entry holding register and always take priority over new read grants.
// Reads are only granted while no download is active, and ties between the
// two readers are broken round-robin. One SDRAM op is in flight at a time.
//
// Parameters:
//   BG_BASE   byte offset added to bg_addr  (25-bit wrap)
//   OBJ_BASE  byte offset added to obj_addr (25-bit wrap)
//   TIMEOUT   watchdog cycles per SDRAM op (only with ARB_TIMEOUT_EN)
//
// Ports:
//   clk_sys    system clock, rising edge
//   reset_n    asynchronous active-low reset
//   bus        gfx_sdram_arbiter_if.master (loader, bg, obj, SDRAM, err)
//   dbg_state  current FSM state (0 idle, 1 write, 2 read)
//
// Build option:
//   ARB_TIMEOUT_EN  when defined, an 8-bit watchdog aborts an SDRAM op that
//                   sees no sd_ready within TIMEOUT cycles: a read is acked
//                   with 8'hFF, a write releases the loader, and err sets
//                   until reset. When undefined the FSM waits indefinitely
//                   and err is tied low.
// -----------------------------------------------------------------------------
module gfx_sdram_arbiter #(
  parameter logic [24:0] BG_BASE  = 25'h0000000,
  parameter logic [24:0] OBJ_BASE = 25'h0040000,
  parameter int          TIMEOUT  = 64
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  gfx_sdram_arbiter_if.master        bus,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_t;

  // The watchdog is 8 bits wide; a TIMEOUT outside 1..255 cannot be counted.
  // This empty block makes such a configuration visible in the elaborated
  // hierarchy.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_out_of_range
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_q,     state_d;
  logic        pend_q,      pend_d;
  logic [24:0] hold_addr_q, hold_addr_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic [24:0] sd_addr_q,   sd_addr_d;
  logic [7:0]  sd_din_q,    sd_din_d;
  logic        sd_rd_q,     sd_rd_d;
  logic        sd_we_q,     sd_we_d;
  logic        bg_ack_q,    bg_ack_d;
  logic        obj_ack_q,   obj_ack_d;
  logic [7:0]  bg_data_q,   bg_data_d;
  logic [7:0]  obj_data_q,  obj_data_d;
  logic        gnt_obj_q,   gnt_obj_d;   // requester owning the in-flight read
  logic        last_obj_q,  last_obj_d;  // requester served by the last read

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  logic [7:0]  wdog_q,      wdog_d;
  logic        err_q,       err_d;
`endif

  // ---------------------------------------------------------------------------
  // Grant and address helpers
  // ---------------------------------------------------------------------------
  logic        any_req;
  logic        pick_obj;
  logic [24:0] bg_full_addr;
  logic [24:0] obj_full_addr;
  logic [24:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_go;

  assign any_req       = bus.bg_req | bus.obj_req;
  // OBJ wins when it is the only requester, or on a tie when BG went last.
  assign pick_obj      = bus.obj_req & (~bus.bg_req | ~last_obj_q);
  assign bg_full_addr  = BG_BASE  + {6'd0, bus.bg_addr};
  assign obj_full_addr = OBJ_BASE + {6'd0, bus.obj_addr};

  // A strobe arriving while the holding register is empty is issued straight
  // from the loader inputs, so sd_we rises in the same cycle as dl_wait.
  assign wr_go   = pend_q | bus.dl_wr;
  assign wr_addr = pend_q ? hold_addr_q : bus.dl_addr;
  assign wr_data = pend_q ? hold_data_q : bus.dl_data;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  logic       rd_done;
  logic       wr_done;
  logic [7:0] rd_byte;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    sd_addr_d   = sd_addr_q;
    sd_din_d    = sd_din_q;
    sd_rd_d     = 1'b0;
    sd_we_d     = 1'b0;
    bg_ack_d    = 1'b0;
    obj_ack_d   = 1'b0;
    bg_data_d   = bg_data_q;
    obj_data_d  = obj_data_q;
    gnt_obj_d   = gnt_obj_q;
    last_obj_d  = last_obj_q;
    rd_done     = 1'b0;
    wr_done     = 1'b0;
    rd_byte     = bus.sd_dout;
`ifdef ARB_TIMEOUT_EN
    wdog_d      = wdog_q;
    err_d       = err_q;
`endif

    // Holding register: a strobe is only accepted when it is empty; a strobe
    // that finds it full is lost (loader ignored dl_wait).
    if (bus.dl_wr && !pend_q) begin
      pend_d      = 1'b1;
      hold_addr_d = bus.dl_addr;
      hold_data_d = bus.dl_data;
    end

    case (state_q)
      S_IDLE: begin
        // sd_ready seen here belongs to no op and is ignored.
        if (wr_go) begin
          sd_addr_d = wr_addr;
          sd_din_d  = wr_data;
          sd_we_d   = 1'b1;
          state_d   = S_WRITE;
`ifdef ARB_TIMEOUT_EN
          wdog_d    = 8'd0;
`endif
        end else if (!bus.dl_active && any_req) begin
          sd_addr_d = pick_obj ? obj_full_addr : bg_full_addr;
          sd_rd_d   = 1'b1;
          gnt_obj_d = pick_obj;
          state_d   = S_READ;
`ifdef ARB_TIMEOUT_EN
          wdog_d    = 8'd0;
`endif
        end
      end

      S_WRITE: begin
        if (bus.sd_ready) begin
          wr_done = 1'b1;
`ifdef ARB_TIMEOUT_EN
        end else if (wdog_q == TIMEOUT_CNT) begin
          wr_done = 1'b1;
          err_d   = 1'b1;
        end else begin
          wdog_d  = wdog_q + 8'd1;
`endif
        end
      end

      S_READ: begin
        if (bus.sd_ready) begin
          rd_done = 1'b1;
`ifdef ARB_TIMEOUT_EN
        end else if (wdog_q == TIMEOUT_CNT) begin
          rd_done = 1'b1;
          rd_byte = 8'hFF;
          err_d   = 1'b1;
        end else begin
          wdog_d  = wdog_q + 8'd1;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (wr_done) begin
      pend_d  = 1'b0;
      state_d = S_IDLE;
    end

    if (rd_done) begin
      state_d    = S_IDLE;
      last_obj_d = gnt_obj_q;
      if (gnt_obj_q) begin
        obj_data_d = rd_byte;
        obj_ack_d  = 1'b1;
      end else begin
        bg_data_d  = rd_byte;
        bg_ack_d   = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset abandons any op in flight without acking it.
  // last resets to OBJ so BG wins the first tie.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pend_q      <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      sd_addr_q   <= '0;
      sd_din_q    <= '0;
      sd_rd_q     <= 1'b0;
      sd_we_q     <= 1'b0;
      bg_ack_q    <= 1'b0;
      obj_ack_q   <= 1'b0;
      bg_data_q   <= '0;
      obj_data_q  <= '0;
      gnt_obj_q   <= 1'b0;
      last_obj_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      sd_addr_q   <= sd_addr_d;
      sd_din_q    <= sd_din_d;
      sd_rd_q     <= sd_rd_d;
      sd_we_q     <= sd_we_d;
      bg_ack_q    <= bg_ack_d;
      obj_ack_q   <= obj_ack_d;
      bg_data_q   <= bg_data_d;
      obj_data_q  <= obj_data_d;
      gnt_obj_q   <= gnt_obj_d;
      last_obj_q  <= last_obj_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs. dl_wait is exactly "holding register full": it rises the cycle
  // after an accepted dl_wr and falls the cycle after the write completes.
  // ---------------------------------------------------------------------------
  assign bus.dl_wait  = pend_q;
  assign bus.sd_addr  = sd_addr_q;
  assign bus.sd_din   = sd_din_q;
  assign bus.sd_rd    = sd_rd_q;
  assign bus.sd_we    = sd_we_q;
  assign bus.bg_ack   = bg_ack_q;
  assign bus.obj_ack  = obj_ack_q;
  assign bus.bg_data  = bg_data_q;
  assign bus.obj_data = obj_data_q;
  assign dbg_state    = state_q;

endmodule
